cpld_ramexp_ctrl: RTL and testbench

//  Parametrised DK'Tronics/Amstrad-compatible RAM expansion controller for CPC CPLD boards.

---
 rtl/cpld_ramexp_ctrl.sv | 148 ++++++++++++++
 tb/tb_cpld_ramexp_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpld_ramexp_ctrl.sv
// DK'Tronics/Amstrad-compatible RAM expansion controller for CPC CPLD boards.
// Decodes 7Fxx-downward config writes, maps Z80 memory cycles onto 512K SRAM pages.
module cpld_ramexp_ctrl #(
    parameter int PAGE_BITS = 1,
    parameter int NPAGES    = 2,
    parameter bit OVERDRIVE = 1'b0,
    parameter bit READBACK  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 iorq_b,
    input  logic                 mreq_b,
    input  logic                 rfsh_b,
    input  logic                 m1_b,
    input  logic                 rd_b,
    input  logic                 wr_b,
    input  logic                 ramrd_b,
    input  logic                 adr15,
    input  logic                 adr14,
    input  logic [PAGE_BITS-1:0] adr_pg,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic                 data_oe,
    output logic [PAGE_BITS+4:0] ramadrhi,
    output logic                 ramcs_b,
    output logic                 ramoe_b,
    output logic                 ramwe_b,
    output logic                 ramdis,
    output logic                 adr15_ovd,
    output logic                 wr_ovd,
    output logic                 rd_ovd
);

    typedef struct packed {
        logic [2:0] bank;
        logic [2:0] cfg;
    } cfg_t;

    typedef enum logic [1:0] {IDLE, MWR1, MWR2, MRD} state_t;

    localparam logic [3:0] NPG = 4'(NPAGES);

    logic                 rst_meta, rst_n;
    cfg_t                 cfg_q;
    logic [PAGE_BITS-1:0] page_q;
    logic                 cardsel_q, mode3_q;
    logic                 iorq_b_q, mreq_b_q, adr15_lat;
    logic [PAGE_BITS+4:0] adrhi_q;
    state_t               state;

    logic [PAGE_BITS-1:0] page_cur;
    logic [3:0]           pg_ext;
    logic                 io_start, mreq_start, reg_wr, adr15_m;
    logic                 exp_sel, hit;
    logic [1:0]           blk;
    logic [PAGE_BITS+4:0] adrhi_hit;

    // Reset asserts immediately, releases two clocks after reset_b rises.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) {rst_n, rst_meta} <= 2'b00;
        else          {rst_n, rst_meta} <= {rst_meta, 1'b1};
    end

    assign page_cur   = ~adr_pg;
    assign pg_ext     = 4'(page_cur);
    assign io_start   = iorq_b_q & ~iorq_b;
    assign mreq_start = mreq_b_q & ~mreq_b;
    assign reg_wr     = io_start & ~wr_b & ~adr15 & (data_in[7:6] == 2'b11);

    // In C3 mode the pad A15 may be overdriven after MREQ falls, so use the value seen at the fall.
    assign adr15_m = mreq_start ? adr15 : adr15_lat;

    always_comb begin
        exp_sel = 1'b0;
        blk     = 2'b00;
        casez (cfg_q.cfg)
            3'b001: if ({adr15, adr14} == 2'b11) begin
                exp_sel = 1'b1;
                blk     = 2'b11;
            end
            3'b010: begin
                exp_sel = 1'b1;
                blk     = {adr15, adr14};
            end
            3'b011: if ({adr15_m, adr14} == 2'b11) begin
                exp_sel = 1'b1;
                blk     = 2'b11;
            end
            3'b1??: if ({adr15, adr14} == 2'b01) begin
                exp_sel = 1'b1;
                blk     = cfg_q.cfg[1:0];
            end
            default: ;
        endcase
    end

    assign adrhi_hit = {page_q, cfg_q.bank, blk};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q     <= '0;
            page_q    <= '0;
            cardsel_q <= 1'b0;
            mode3_q   <= 1'b0;
            iorq_b_q  <= 1'b1;
            mreq_b_q  <= 1'b1;
            adr15_lat <= 1'b0;
            adrhi_q   <= '0;
            state     <= IDLE;
        end else begin
            iorq_b_q <= iorq_b;
            mreq_b_q <= mreq_b;
            if (mreq_start) adr15_lat <= adr15;
            if (exp_sel && !mreq_b) adrhi_q <= adrhi_hit;
            if (reg_wr) begin
                cfg_q     <= data_in[5:0];
                page_q    <= page_cur;
                cardsel_q <= (pg_ext < NPG);
                mode3_q   <= (data_in[2:0] == 3'b011);
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: if (mreq_start && rfsh_b)
                        state <= (m1_b && rd_b) ? MWR1 : MRD;
                    MWR1: state <= MWR2;
                    MWR2: if (mreq_b) state <= IDLE;
                    MRD:  if (mreq_b) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ramadrhi = exp_sel ? adrhi_hit : adrhi_q;
    assign ramcs_b  = ~(exp_sel & cardsel_q) | mreq_b | ~rfsh_b;
    assign ramdis   = ~ramcs_b;
    assign ramoe_b  = ramrd_b;
    assign ramwe_b  = wr_b;

    assign hit       = exp_sel & ~mreq_b;
    assign adr15_ovd = OVERDRIVE & mode3_q & adr14 & rfsh_b & ~mreq_b;
    assign wr_ovd    = OVERDRIVE & hit & (state == MWR1);
    assign rd_ovd    = OVERDRIVE & hit & ((state == MWR1) | (state == MWR2));

    assign data_oe  = READBACK & rst_n & ~iorq_b & ~rd_b & ~adr15 & (pg_ext < NPG);
    assign data_out = data_oe ? {2'b11, cfg_q} : 8'h00;

endmodule

// File: tb/tb_cpld_ramexp_ctrl.sv
// Directed bench: instance A uses defaults, instance B is 2 page bits / 3 pages / overdrive / no readback.
module tb_cpld_ramexp_ctrl;

    logic clk, reset_b, iorq_b, mreq_b, rfsh_b, m1_b, rd_b, wr_b, ramrd_b, adr15, adr14;
    logic [1:0] adr_pg;
    logic [7:0] data_in;

    logic [7:0] a_data_out, b_data_out;
    logic       a_data_oe, b_data_oe;
    logic [5:0] a_ramadrhi;
    logic [6:0] b_ramadrhi;
    logic a_ramcs_b, a_ramoe_b, a_ramwe_b, a_ramdis, a_adr15_ovd, a_wr_ovd, a_rd_ovd;
    logic b_ramcs_b, b_ramoe_b, b_ramwe_b, b_ramdis, b_adr15_ovd, b_wr_ovd, b_rd_ovd;

    int checks = 0;
    int failures = 0;

    cpld_ramexp_ctrl dut_a (
        .clk(clk), .reset_b(reset_b), .iorq_b(iorq_b), .mreq_b(mreq_b), .rfsh_b(rfsh_b),
        .m1_b(m1_b), .rd_b(rd_b), .wr_b(wr_b), .ramrd_b(ramrd_b), .adr15(adr15), .adr14(adr14),
        .adr_pg(adr_pg[0]), .data_in(data_in), .data_out(a_data_out), .data_oe(a_data_oe),
        .ramadrhi(a_ramadrhi), .ramcs_b(a_ramcs_b), .ramoe_b(a_ramoe_b), .ramwe_b(a_ramwe_b),
        .ramdis(a_ramdis), .adr15_ovd(a_adr15_ovd), .wr_ovd(a_wr_ovd), .rd_ovd(a_rd_ovd)
    );

    cpld_ramexp_ctrl #(.PAGE_BITS(2), .NPAGES(3), .OVERDRIVE(1'b1), .READBACK(1'b0)) dut_b (
        .clk(clk), .reset_b(reset_b), .iorq_b(iorq_b), .mreq_b(mreq_b), .rfsh_b(rfsh_b),
        .m1_b(m1_b), .rd_b(rd_b), .wr_b(wr_b), .ramrd_b(ramrd_b), .adr15(adr15), .adr14(adr14),
        .adr_pg(adr_pg), .data_in(data_in), .data_out(b_data_out), .data_oe(b_data_oe),
        .ramadrhi(b_ramadrhi), .ramcs_b(b_ramcs_b), .ramoe_b(b_ramoe_b), .ramwe_b(b_ramwe_b),
        .ramdis(b_ramdis), .adr15_ovd(b_adr15_ovd), .wr_ovd(b_wr_ovd), .rd_ovd(b_rd_ovd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_bus();
        iorq_b = 1; mreq_b = 1; rfsh_b = 1; m1_b = 1; rd_b = 1; wr_b = 1; ramrd_b = 1;
        adr15 = 0; adr14 = 0; adr_pg = 2'b11; data_in = 8'h00;
    endtask

    task automatic do_reset();
        reset_b = 1'b0;
        idle_bus();
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic io_out(input logic [1:0] pg, input logic [7:0] d);
        @(negedge clk);
        adr15 = 0; adr_pg = pg; data_in = d; iorq_b = 0; wr_b = 0;
        @(negedge clk);
        iorq_b = 1; wr_b = 1;
        @(negedge clk);
    endtask

    task automatic mem_begin(input logic a15, input logic a14, input logic rd);
        @(negedge clk);
        adr15 = a15; adr14 = a14; m1_b = 1; rd_b = ~rd; ramrd_b = ~rd; mreq_b = 0;
        #1;
    endtask

    task automatic mem_end();
        @(negedge clk);
        mreq_b = 1; rd_b = 1; wr_b = 1; ramrd_b = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        idle_bus();
        #1;
        checks++; if (a_ramcs_b !== 1'b1 || a_ramdis !== 1'b0) begin failures++;
            $display("FAIL rst_a_cs got cs=%b dis=%b exp cs=1 dis=0", a_ramcs_b, a_ramdis); end
        checks++; if (b_adr15_ovd !== 1'b0 || b_wr_ovd !== 1'b0 || b_rd_ovd !== 1'b0) begin failures++;
            $display("FAIL rst_b_ovd got %b%b%b exp 000", b_adr15_ovd, b_wr_ovd, b_rd_ovd); end
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
        mem_begin(1, 1, 1);
        checks++; if (a_ramcs_b !== 1'b1 || a_ramdis !== 1'b0 || a_ramadrhi !== 6'd0) begin failures++;
            $display("FAIL t1_read_c000 got cs=%b dis=%b hi=%b exp 1 0 000000", a_ramcs_b, a_ramdis, a_ramadrhi); end
        checks++; if (b_adr15_ovd !== 1'b0 || b_wr_ovd !== 1'b0 || b_rd_ovd !== 1'b0 || b_ramcs_b !== 1'b1) begin failures++;
            $display("FAIL t1_b_ovd got ovd=%b%b%b cs=%b exp 000 1", b_adr15_ovd, b_wr_ovd, b_rd_ovd, b_ramcs_b); end
        checks++; if (a_ramoe_b !== 1'b0 || a_ramwe_b !== 1'b1 || a_data_oe !== 1'b0) begin failures++;
            $display("FAIL t1_passthru got oe=%b we=%b doe=%b exp 0 1 0", a_ramoe_b, a_ramwe_b, a_data_oe); end
        mem_end();
    endtask

    task automatic test_map_basic();
        io_out(2'b11, 8'hC2);
        mem_begin(1, 0, 1);
        checks++; if (a_ramcs_b !== 1'b0 || a_ramdis !== 1'b1 || a_ramadrhi !== 6'b0_000_10) begin failures++;
            $display("FAIL t2_read_8000 got cs=%b dis=%b hi=%b exp 0 1 000010", a_ramcs_b, a_ramdis, a_ramadrhi); end
        checks++; if (b_ramadrhi !== 7'b00_000_10) begin failures++;
            $display("FAIL t2_b_hi got %b exp 0000010", b_ramadrhi); end
        mem_end();
        // Refresh cycle at a mapped address: no select, FSM stays idle.
        @(negedge clk);
        rfsh_b = 0; adr15 = 1; adr14 = 0; mreq_b = 0;
        #1;
        checks++; if (a_ramcs_b !== 1'b1) begin failures++;
            $display("FAIL t2_refresh_cs got %b exp 1", a_ramcs_b); end
        @(negedge clk);
        checks++; if (b_wr_ovd !== 1'b0 || b_rd_ovd !== 1'b0) begin failures++;
            $display("FAIL t2_refresh_fsm got wr=%b rd=%b exp 0 0", b_wr_ovd, b_rd_ovd); end
        mem_end();
        rfsh_b = 1;
    endtask

    task automatic test_page_bank();
        io_out(2'b10, 8'hCC);
        mem_begin(0, 1, 1);
        checks++; if (a_ramcs_b !== 1'b0 || a_ramadrhi !== 6'b1_001_00) begin failures++;
            $display("FAIL t3_read_4000 got cs=%b hi=%b exp 0 100100", a_ramcs_b, a_ramadrhi); end
        mem_end();
        mem_begin(1, 1, 1);
        checks++; if (a_ramcs_b !== 1'b1 || a_ramadrhi !== 6'b1_001_00) begin failures++;
            $display("FAIL t3_read_c000 got cs=%b hi=%b exp 1 100100", a_ramcs_b, a_ramadrhi); end
        mem_end();
        // Gate-array style write (top bits 10) must be ignored.
        io_out(2'b11, 8'h82);
        mem_begin(0, 1, 1);
        checks++; if (a_ramcs_b !== 1'b0 || a_ramadrhi !== 6'b1_001_00) begin failures++;
            $display("FAIL t3_ignore_82 got cs=%b hi=%b exp 0 100100", a_ramcs_b, a_ramadrhi); end
        mem_end();
    endtask

    task automatic test_capture_once();
        @(negedge clk);
        adr15 = 0; adr_pg = 2'b11; data_in = 8'hC2; iorq_b = 0; wr_b = 0;
        @(negedge clk);
        data_in = 8'hC0;
        @(negedge clk);
        iorq_b = 1; wr_b = 1;
        @(negedge clk);
        mem_begin(1, 0, 1);
        checks++; if (a_ramcs_b !== 1'b0 || a_ramadrhi !== 6'b0_000_10) begin failures++;
            $display("FAIL cap_once got cs=%b hi=%b exp 0 000010", a_ramcs_b, a_ramadrhi); end
        mem_end();
    endtask

    task automatic test_npages();
        io_out(2'b00, 8'hC2);
        mem_begin(1, 0, 1);
        checks++; if (b_ramcs_b !== 1'b1 || b_ramdis !== 1'b0) begin failures++;
            $display("FAIL t4_page3_desel got cs=%b dis=%b exp 1 0", b_ramcs_b, b_ramdis); end
        checks++; if (a_ramcs_b !== 1'b0) begin failures++;
            $display("FAIL t4_a_page1 got cs=%b exp 0", a_ramcs_b); end
        mem_end();
        io_out(2'b01, 8'hC2);
        mem_begin(1, 0, 1);
        checks++; if (b_ramcs_b !== 1'b0 || b_ramadrhi !== 7'b10_000_10) begin failures++;
            $display("FAIL t4_page2_sel got cs=%b hi=%b exp 0 1000010", b_ramcs_b, b_ramadrhi); end
        mem_end();
    endtask

    task automatic test_overdrive();
        io_out(2'b11, 8'hC3);
        mem_begin(0, 1, 0);
        checks++; if (b_adr15_ovd !== 1'b1 || a_adr15_ovd !== 1'b0) begin failures++;
            $display("FAIL t5_a15ovd got b=%b a=%b exp 1 0", b_adr15_ovd, a_adr15_ovd); end
        @(posedge clk);
        #1;
        adr15 = 1; wr_b = 0;
        #1;
        checks++; if (b_ramcs_b !== 1'b1 || b_wr_ovd !== 1'b0 || b_adr15_ovd !== 1'b1) begin failures++;
            $display("FAIL t5_4000_latched got cs=%b wr=%b a15=%b exp 1 0 1", b_ramcs_b, b_wr_ovd, b_adr15_ovd); end
        mem_end();
        checks++; if (b_adr15_ovd !== 1'b0) begin failures++;
            $display("FAIL t5_a15ovd_end got %b exp 0", b_adr15_ovd); end

        mem_begin(1, 1, 0);
        checks++; if (b_ramcs_b !== 1'b0 || b_wr_ovd !== 1'b0) begin failures++;
            $display("FAIL t5_c000_idle got cs=%b wr=%b exp 0 0", b_ramcs_b, b_wr_ovd); end
        @(negedge clk);
        checks++; if (b_wr_ovd !== 1'b1 || b_rd_ovd !== 1'b1) begin failures++;
            $display("FAIL t5_mwr1 got wr=%b rd=%b exp 1 1", b_wr_ovd, b_rd_ovd); end
        wr_b = 0;
        @(negedge clk);
        checks++; if (b_wr_ovd !== 1'b0 || b_rd_ovd !== 1'b1) begin failures++;
            $display("FAIL t5_mwr2 got wr=%b rd=%b exp 0 1", b_wr_ovd, b_rd_ovd); end
        @(negedge clk);
        checks++; if (b_rd_ovd !== 1'b1 || a_rd_ovd !== 1'b0) begin failures++;
            $display("FAIL t5_mwr2_hold got b=%b a=%b exp 1 0", b_rd_ovd, a_rd_ovd); end
        mreq_b = 1; wr_b = 1;
        #1;
        checks++; if (b_rd_ovd !== 1'b0) begin failures++;
            $display("FAIL t5_rd_release got %b exp 0", b_rd_ovd); end
        repeat (2) @(negedge clk);

        mem_begin(1, 1, 0);
        @(negedge clk);
        wr_b = 0;
        reset_b = 0;
        #1;
        checks++; if (b_wr_ovd !== 1'b0 || b_rd_ovd !== 1'b0 || b_adr15_ovd !== 1'b0) begin failures++;
            $display("FAIL t5_rst_ovd got %b%b%b exp 000", b_wr_ovd, b_rd_ovd, b_adr15_ovd); end
        checks++; if (b_ramcs_b !== 1'b1 || b_ramdis !== 1'b0 || b_ramadrhi !== 7'd0) begin failures++;
            $display("FAIL t5_rst_ram got cs=%b dis=%b hi=%b exp 1 0 0000000", b_ramcs_b, b_ramdis, b_ramadrhi); end
        idle_bus();
        repeat (2) @(negedge clk);
        reset_b = 1;
        repeat (3) @(negedge clk);
        io_out(2'b11, 8'hC3);
        mem_begin(1, 1, 0);
        @(negedge clk);
        checks++; if (b_wr_ovd !== 1'b1) begin failures++;
            $display("FAIL t5_fsm_restart got %b exp 1", b_wr_ovd); end
        mem_end();
    endtask

    task automatic test_readback();
        io_out(2'b11, 8'hC5);
        @(negedge clk);
        adr15 = 0; adr_pg = 2'b11; iorq_b = 0; rd_b = 0;
        #1;
        checks++; if (a_data_oe !== 1'b1 || a_data_out !== 8'hC5) begin failures++;
            $display("FAIL t6_in_7f got oe=%b d=%h exp 1 c5", a_data_oe, a_data_out); end
        checks++; if (b_data_oe !== 1'b0 || b_data_out !== 8'h00) begin failures++;
            $display("FAIL t6_noreadback got oe=%b d=%h exp 0 00", b_data_oe, b_data_out); end
        adr15 = 1;
        #1;
        checks++; if (a_data_oe !== 1'b0 || a_data_out !== 8'h00) begin failures++;
            $display("FAIL t6_a15_high got oe=%b d=%h exp 0 00", a_data_oe, a_data_out); end
        adr15 = 0; adr_pg = 2'b10;
        #1;
        checks++; if (a_data_oe !== 1'b1 || a_data_out !== 8'hC5) begin failures++;
            $display("FAIL t6_in_7e got oe=%b d=%h exp 1 c5", a_data_oe, a_data_out); end
        @(negedge clk);
        idle_bus();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset_b = 1'b1;
        idle_bus();
        test_reset();
        test_map_basic();
        test_page_bank();
        test_capture_once();
        test_npages();
        test_overdrive();
        test_readback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
